// File: rtl/mac_rx_ctrl.sv
// mac_rx_ctrl: receive-side MAC controller.
// Takes decoded 32-bit XGMII-style words and recognises Start, preamble and SFD.
// It strips the header and FCS and streams the payload as AXI-Stream beats, with
// no backpressure. It drives an external CRC-32 engine and reports frame errors
// (CRC, runt, oversize, stray control) on tuser of the tlast beat.
// Optional build macro: MAC_RX_STATS_EN adds o_good_frames / o_bad_frames counters.

// Per-lane byte classifier: one instance per lane, so the word decode is a plain AND/OR of lanes.
module mac_rx_lane #(
  parameter int W_BYTE     = 8,
  parameter int LANE       = 0,
  parameter int N_CHANNELS = 4
) (
  input  logic              ctrl,
  input  logic [W_BYTE-1:0] data,
  output logic              is_term,
  output logic              is_junk,
  output logic              start_ok,
  output logic              sfd_ok
);
  localparam logic [W_BYTE-1:0] SYM_START = W_BYTE'(8'hFB);
  localparam logic [W_BYTE-1:0] SYM_TERM  = W_BYTE'(8'hFD);
  localparam logic [W_BYTE-1:0] SYM_IDLE  = W_BYTE'(8'h07);
  localparam logic [W_BYTE-1:0] PRE_BYTE  = W_BYTE'(8'h55);
  localparam logic [W_BYTE-1:0] SFD_BYTE  = W_BYTE'(8'hD5);
  // byte this lane must carry in the Start word and in the preamble/SFD word
  localparam logic [W_BYTE-1:0] START_EXP = (LANE == 0) ? SYM_START : PRE_BYTE;
  localparam logic [W_BYTE-1:0] SFD_EXP   = (LANE == N_CHANNELS-1) ? SFD_BYTE : PRE_BYTE;

  assign is_term  = ctrl && (data == SYM_TERM);
  assign is_junk  = ctrl && (data != SYM_IDLE);
  assign start_ok = (data == START_EXP);
  assign sfd_ok   = (data == SFD_EXP);
endmodule

module mac_rx_ctrl #(
  parameter int          N_CHANNELS    = 4,
  parameter int          W_BYTE        = 8,
  parameter int          MIN_FRAME_LEN = 64,
  parameter int          MAX_FRAME_LEN = 1518,
  parameter logic [31:0] CRC_RESIDUE   = 32'hC704DD7B,
  parameter int          W_LEN         = 14
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset_n,
  input  logic                                 i_clk_en,
  input  logic [N_CHANNELS-1:0]                i_ctrl,
  input  logic [N_CHANNELS-1:0][W_BYTE-1:0]    i_data,
  output logic                                 m_axis_tvalid,
  output logic [N_CHANNELS-1:0][W_BYTE-1:0]    m_axis_tdata,
  output logic [N_CHANNELS-1:0]                m_axis_tkeep,
  output logic                                 m_axis_tlast,
  output logic                                 m_axis_tuser,
  output logic                                 o_crc_clear,
  output logic [N_CHANNELS-1:0]                o_crc_en,
  output logic [N_CHANNELS-1:0][W_BYTE-1:0]    o_crc_data,
`ifdef MAC_RX_STATS_EN
  output logic [31:0]                          o_good_frames,
  output logic [31:0]                          o_bad_frames,
`endif
  input  logic [31:0]                          i_crc
);
  localparam int W_K = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam logic [W_LEN-1:0] MIN_L = W_LEN'(MIN_FRAME_LEN);
  localparam logic [W_LEN-1:0] MAX_L = W_LEN'(MAX_FRAME_LEN);

  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_DATA, ST_FLUSH} state_t;
  typedef logic [N_CHANNELS-1:0][W_BYTE-1:0] word_t;
  typedef struct packed {
    word_t                 data;
    logic [N_CHANNELS-1:0] keep;
    logic                  last;
    logic                  user;
  } beat_t;

  state_t                st_q, st_nxt;
  word_t                 a_q, b_q;          // A = newest word, B = older word
  logic                  a_vld, b_vld;
  logic [W_LEN-1:0]      len_q, len_nxt;
  logic                  err_q, err_nxt;
  logic [W_K-1:0]        k_q, k_nxt;        // term lane, kept for the flush beat
  beat_t                 beat_nxt;
  logic                  emit, shift, clr, drop, crc_clear;
  logic [N_CHANNELS-1:0] crc_en;

  logic [N_CHANNELS-1:0] lane_term, lane_junk, lane_start, lane_sfd;
  logic [N_CHANNELS-1:0] low_mask, high_mask, flush_mask;
  logic [W_K-1:0]        k_lane;
  logic                  is_data, is_term, is_start, is_sfd, junk_above, crc_bad;

  for (genvar g = 0; g < N_CHANNELS; g++) begin : g_lane
    mac_rx_lane #(.W_BYTE(W_BYTE), .LANE(g), .N_CHANNELS(N_CHANNELS)) u_lane (
      .ctrl     (i_ctrl[g]),
      .data     (i_data[g]),
      .is_term  (lane_term[g]),
      .is_junk  (lane_junk[g]),
      .start_ok (lane_start[g]),
      .sfd_ok   (lane_sfd[g])
    );
  end

  // lowest control lane plus lane masks below/above it and below the stored term lane
  always_comb begin
    k_lane = '0;
    for (int j = N_CHANNELS-1; j >= 0; j--)
      if (i_ctrl[j]) k_lane = W_K'(j);
    for (int j = 0; j < N_CHANNELS; j++) begin
      low_mask[j]   = (j < int'(k_lane));
      high_mask[j]  = (j > int'(k_lane));
      flush_mask[j] = (j < int'(k_q));
    end
  end

  assign is_data    = (i_ctrl == '0);
  assign is_term    = lane_term[k_lane];
  assign is_start   = (i_ctrl == N_CHANNELS'(1)) && (&lane_start);
  assign is_sfd     = is_data && (&lane_sfd);
  assign junk_above = |(lane_junk & high_mask);
  assign crc_bad    = (i_crc != CRC_RESIDUE);

  function automatic logic [W_LEN-1:0] len_add(input logic [W_LEN-1:0] len,
                                               input logic [W_K:0]     inc);
    logic [W_LEN:0] sum;
    sum = {1'b0, len} + {{(W_LEN-W_K){1'b0}}, inc};
    return sum[W_LEN] ? '1 : sum[W_LEN-1:0];
  endfunction

  function automatic logic len_bad(input logic [W_LEN-1:0] len);
    return (len < MIN_L) || (len > MAX_L);
  endfunction

  // next state, hold-register control and the beat to emit this word
  always_comb begin
    st_nxt        = st_q;
    emit          = 1'b0;
    shift         = 1'b0;
    clr           = 1'b0;
    drop          = 1'b0;
    crc_clear     = 1'b0;
    crc_en        = '0;
    len_nxt       = len_q;
    err_nxt       = err_q;
    k_nxt         = k_q;
    beat_nxt.data = b_q;
    beat_nxt.keep = '1;
    beat_nxt.last = 1'b0;
    beat_nxt.user = 1'b0;
    case (st_q)
      ST_IDLE: begin
        crc_clear = 1'b1;
        if (is_start) st_nxt = ST_PRE;
      end
      ST_PRE: begin
        if (is_sfd) begin
          st_nxt  = ST_DATA;
          clr     = 1'b1;
          len_nxt = '0;
          err_nxt = 1'b0;
        end else begin
          st_nxt = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (is_data) begin
          crc_en  = '1;
          len_nxt = len_add(len_q, (W_K+1)'(N_CHANNELS));
          shift   = 1'b1;
          emit    = b_vld;
        end else if (is_term) begin
          // lanes below the term are the tail of the FCS
          crc_en  = low_mask;
          len_nxt = len_add(len_q, {1'b0, k_lane});
          err_nxt = err_q | junk_above;
          k_nxt   = k_lane;
          if (!b_vld) begin
            drop   = 1'b1;
            st_nxt = ST_IDLE;
          end else if (k_lane == '0) begin
            // A is all FCS; CRC already covers it, so B closes the frame now
            emit          = 1'b1;
            beat_nxt.last = 1'b1;
            beat_nxt.user = err_nxt | crc_bad | len_bad(len_nxt);
            st_nxt        = ST_IDLE;
          end else begin
            emit   = 1'b1;
            st_nxt = ST_FLUSH;
          end
        end else begin
          // idle/error/start mid-frame: close whatever was emitted as bad
          emit          = b_vld;
          beat_nxt.last = 1'b1;
          beat_nxt.user = 1'b1;
          st_nxt        = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        // CRC engine has now absorbed the FCS bytes of the term word
        emit          = 1'b1;
        beat_nxt.data = a_q;
        beat_nxt.keep = flush_mask;
        beat_nxt.last = 1'b1;
        beat_nxt.user = err_q | crc_bad | len_bad(len_q);
        st_nxt        = ST_IDLE;
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  assign o_crc_clear = i_clk_en & crc_clear;
  assign o_crc_en    = i_clk_en ? crc_en : '0;
  assign o_crc_data  = i_data;

  // frame state, length/error accumulation and the two-word hold pipeline
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      st_q  <= ST_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      a_vld <= 1'b0;
      b_vld <= 1'b0;
      len_q <= '0;
      err_q <= 1'b0;
      k_q   <= '0;
    end else if (i_clk_en) begin
      st_q  <= st_nxt;
      len_q <= len_nxt;
      err_q <= err_nxt;
      k_q   <= k_nxt;
      if (clr) begin
        a_vld <= 1'b0;
        b_vld <= 1'b0;
      end else if (shift) begin
        b_q   <= a_q;
        b_vld <= a_vld;
        a_q   <= i_data;
        a_vld <= 1'b1;
      end
    end
  end

  // registered AXI-Stream output; tvalid is a one-cycle pulse per beat
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else if (!i_clk_en) begin
      m_axis_tvalid <= 1'b0;
    end else begin
      m_axis_tvalid <= emit;
      if (emit) begin
        m_axis_tdata <= beat_nxt.data;
        m_axis_tkeep <= beat_nxt.keep;
        m_axis_tlast <= beat_nxt.last;
        m_axis_tuser <= beat_nxt.user;
      end
    end
  end

`ifdef MAC_RX_STATS_EN
  // wrapping frame counters: closed frames by tuser, silent drops count as bad
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_good_frames <= '0;
      o_bad_frames  <= '0;
    end else if (i_clk_en) begin
      if (emit && beat_nxt.last && !beat_nxt.user) o_good_frames <= o_good_frames + 32'd1;
      if ((emit && beat_nxt.last && beat_nxt.user) || drop) o_bad_frames <= o_bad_frames + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_rx_ctrl.sv
// Testbench for mac_rx_ctrl: random frames through a byte-level model, scoreboard of expected beats.
`timescale 1ns/1ps
module tb_mac_rx_ctrl;
  logic             i_clk = 1'b0;
  logic             i_reset_n;
  logic             i_clk_en;
  logic [3:0]       i_ctrl;
  logic [3:0][7:0]  i_data;
  logic             m_axis_tvalid;
  logic [3:0][7:0]  m_axis_tdata;
  logic [3:0]       m_axis_tkeep;
  logic             m_axis_tlast;
  logic             m_axis_tuser;
  logic             o_crc_clear;
  logic [3:0]       o_crc_en;
  logic [3:0][7:0]  o_crc_data;
  logic [31:0]      i_crc;
`ifdef MAC_RX_STATS_EN
  logic [31:0]      o_good_frames, o_bad_frames;
`endif

  always #5 i_clk = ~i_clk;

  mac_rx_ctrl dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_clk_en(i_clk_en),
    .i_ctrl(i_ctrl), .i_data(i_data),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .o_crc_clear(o_crc_clear), .o_crc_en(o_crc_en), .o_crc_data(o_crc_data),
`ifdef MAC_RX_STATS_EN
    .o_good_frames(o_good_frames), .o_bad_frames(o_bad_frames),
`endif
    .i_crc(i_crc)
  );

  // standard reflected CRC-32 (poly EDB88320), one byte
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [3:0] en,
                                           input logic [3:0][7:0] d);
    logic [31:0] r;
    r = c;
    for (int j = 0; j < 4; j++) if (en[j]) r = crc_byte(r, d[j]);
    return r;
  endfunction

  // external CRC engine model; presented MSB-first so a good frame leaves C704DD7B
  logic [31:0] crc_st;
  always @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n)       crc_st <= '1;
    else if (o_crc_clear) crc_st <= '1;
    else                  crc_st <= crc_step(crc_st, o_crc_en, o_crc_data);
  always_comb for (int i = 0; i < 32; i++) i_crc[i] = crc_st[31-i];

  typedef struct {
    logic [3:0][7:0] data;
    logic [3:0]      keep;
    logic            last;
    logic            user;
  } exp_t;
  exp_t exp_q[$];
  int   n_chk = 0, n_fail = 0;
  int   good_exp = 0, bad_exp = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor_beat();
    exp_t e;
    logic [31:0] md_a, md_e;
    if (exp_q.size() == 0) begin
      check("unexpected_beat", 64'(m_axis_tvalid), 64'd0);
    end else begin
      e = exp_q.pop_front();
      for (int j = 0; j < 4; j++) begin
        md_a[8*j +: 8] = e.keep[j] ? m_axis_tdata[j] : 8'h00;
        md_e[8*j +: 8] = e.keep[j] ? e.data[j] : 8'h00;
      end
      check("beat{data,keep,last,user}",
            64'({md_a, m_axis_tkeep, m_axis_tlast, m_axis_tuser & e.last}),
            64'({md_e, e.keep, e.last, e.user}));
    end
  endtask

  // one valid word, sometimes preceded by clk_en-low cycles carrying garbage
  task automatic drive(input logic [3:0] c, input logic [3:0][7:0] d);
    if ($urandom_range(0, 4) == 0) begin
      repeat ($urandom_range(1, 2)) begin
        i_clk_en = 1'b0;
        i_ctrl   = 4'($urandom);
        i_data   = $urandom;
        @(posedge i_clk); #1;
      end
    end
    i_clk_en = 1'b1;
    i_ctrl   = c;
    i_data   = d;
    @(posedge i_clk); #1;
    i_clk_en = 1'b0;
  endtask

  task automatic idle();
    drive(4'hF, {4{8'h07}});
  endtask

  // cut_at >= 0: stop after that many data words (abort word, or reset if cut_rst)
  task automatic send_frame(input int plen, input bit corrupt, input bit bad_sfd,
                            input int cut_at, input bit cut_rst, input bit junk);
    logic [7:0]      fr[$];
    logic [31:0]     c;
    logic [3:0][7:0] w;
    logic [3:0]      wc;
    int              total, nw, r, idx, n_data;
    bit              err;
    exp_t            e;
    for (int i = 0; i < plen; i++) fr.push_back(8'($urandom));
    c = '1;
    for (int i = 0; i < plen; i++) c = crc_byte(c, fr[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
    if (corrupt) begin
      idx = int'($urandom_range(0, plen-1));
      fr[idx] = fr[idx] ^ (8'h01 << $urandom_range(0, 7));
    end
    total = fr.size();
    nw    = total / 4;
    r     = total % 4;

    // expected beats from the frame's byte content
    if (!bad_sfd) begin
      if (cut_at >= 0) begin
        for (int i = 0; i < cut_at - (cut_rst ? 2 : 1); i++) begin
          for (int j = 0; j < 4; j++) e.data[j] = fr[4*i+j];
          e.keep = 4'hF;
          e.last = !cut_rst && (i == cut_at - 2);
          e.user = e.last;
          exp_q.push_back(e);
        end
        if (!cut_rst && cut_at >= 2) bad_exp++;
      end else if (total < 8) begin
        bad_exp++;
      end else begin
        err = corrupt || (total < 64) || (total > 1518) || (junk && r < 3);
        for (int i = 0; i < plen; i += 4) begin
          for (int j = 0; j < 4; j++) begin
            e.keep[j] = (i + j < plen);
            e.data[j] = (i + j < plen) ? fr[i+j] : 8'h00;
          end
          e.last = (i + 4 >= plen);
          e.user = e.last && err;
          exp_q.push_back(e);
        end
        if (err) bad_exp++; else good_exp++;
      end
    end

    drive(4'b0001, {8'h55, 8'h55, 8'h55, 8'hFB});
    drive(4'b0000, {(bad_sfd ? 8'hD4 : 8'hD5), 8'h55, 8'h55, 8'h55});
    n_data = (cut_at >= 0) ? cut_at : nw;
    for (int i = 0; i < n_data; i++) begin
      for (int j = 0; j < 4; j++) w[j] = fr[4*i+j];
      drive(4'b0000, w);
    end
    if (cut_at >= 0 && cut_rst) begin
      @(negedge i_clk); #1;
      i_reset_n = 1'b0;
      @(posedge i_clk); #1;
      check("tvalid_after_reset", 64'(m_axis_tvalid), 64'd0);
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_reset_n = 1'b1;
      good_exp  = 0;
      bad_exp   = 0;
    end else if (cut_at >= 0) begin
      idle();
    end else begin
      for (int j = 0; j < 4; j++) begin
        if (j < r)       begin wc[j] = 1'b0; w[j] = fr[4*nw+j]; end
        else if (j == r) begin wc[j] = 1'b1; w[j] = 8'hFD; end
        else             begin wc[j] = 1'b1; w[j] = (junk && j == 3) ? 8'hFE : 8'h07; end
      end
      drive(wc, w);
    end
    idle(); idle(); idle();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge i_clk);
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_clk_en  = 1'b0;
    i_ctrl    = '0;
    i_data    = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tdata_keep", 64'({m_axis_tdata, m_axis_tkeep}), 64'd0);
    check("rst_tlast_tuser", 64'({m_axis_tlast, m_axis_tuser}), 64'd0);
    check("rst_crc_en", 64'(o_crc_en), 64'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;

    fork
      forever begin
        @(negedge i_clk);
        if (i_reset_n && m_axis_tvalid) monitor_beat();
      end
    join_none

    idle(); idle();
    send_frame(60,   0, 0, -1, 0, 0);   // 64B, term lane 0
    send_frame(61,   0, 0, -1, 0, 0);   // 65B, term lane 1, flush keep 1
    send_frame(60,   1, 0, -1, 0, 0);   // CRC error
    send_frame(60,   0, 1, -1, 0, 0);   // bad SFD: nothing
    send_frame(60,   0, 0, -1, 0, 0);   // next frame intact
    send_frame(36,   0, 0, -1, 0, 0);   // 40B runt
    send_frame(60,   0, 0, 10, 0, 0);   // idle word after 10 words
    send_frame(61,   0, 0, -1, 0, 1);   // stray control after term
    send_frame(59,   0, 0, -1, 0, 0);   // 63B runt
    send_frame(1514, 0, 0, -1, 0, 0);   // exactly max
    send_frame(1515, 0, 0, -1, 0, 0);   // oversize by one
    send_frame(3,    0, 0, -1, 0, 0);   // too short to emit: dropped
    send_frame(4,    0, 0, -1, 0, 0);   // smallest emitted frame (runt)
    send_frame(62,   0, 0, -1, 0, 0);   // term lane 2
    send_frame(63,   0, 0, -1, 0, 0);   // term lane 3
    for (int n = 0; n < 20; n++)
      send_frame(int'($urandom_range(1, 200)), ($urandom_range(0, 3) == 0),
                 1'b0, -1, 1'b0, ($urandom_range(0, 4) == 0));
    drain("drain_main");

    send_frame(60, 0, 0, 5, 1, 0);      // reset mid-frame
    drain("drain_reset");

    send_frame(60, 0, 0, -1, 0, 0);
    send_frame(61, 0, 0, -1, 0, 0);
    send_frame(70, 1, 0, -1, 0, 0);
    send_frame(62, 0, 0, -1, 0, 0);
    drain("drain_stats");
`ifdef MAC_RX_STATS_EN
    check("good_frames", 64'(o_good_frames), 64'(good_exp));
    check("bad_frames",  64'(o_bad_frames),  64'(bad_exp));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
